// File: rtl/mat_product_mac.sv
// mat_product_mac
//   Signed fixed-point matrix product C = A*B, or C += A*B when accumulate is
//   sampled high together with A. Elements are Q(DATA_W-FRAC_W).FRAC_W two's
//   complement. N_LANES MAC lanes each compute one C element per batch. A
//   batch is N multiply-accumulate cycles followed by one writeback cycle.
//
//   Matrix packing (all three buses): element [r][c] of a matrix with C_COLS
//   columns occupies bits [(r*C_COLS+c)*DATA_W +: DATA_W], so [0][0] sits in
//   the least significant bits.
//
//   Handshake (all three channels): the owner of ack/stb drives it from a
//   register. A word moves on the rising edge where stb && ack are both high.
//   The side that owns ack/stb drops it on that same edge, so it is low in the
//   following cycle. A producer may hold stb high indefinitely while the block
//   is not ready; nothing is consumed without ack.
//
//   Build option: define MAT_PRODUCT_MAC_SAT_EN to saturate results to the
//   DATA_W range. Without it, results wrap (low DATA_W bits are kept).
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   input_mat_1 / _stb / _ack     matrix A [M][N] channel
//   accumulate                    sampled with A: add the product to held C
//   input_mat_2 / _stb / _ack     matrix B [N][P] channel
//   output_mat / _stb / _ack      matrix C [M][P] channel, output_mat registered
//   busy                          high from A transfer until C transfer
//   fsm_state                     current FSM state (debug observation)
module mat_product_mac #(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int P       = 4,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int N_LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [M*N*DATA_W-1:0]   input_mat_1,
  input  logic                    input_mat_1_stb,
  output logic                    input_mat_1_ack,
  input  logic                    accumulate,
  input  logic [N*P*DATA_W-1:0]   input_mat_2,
  input  logic                    input_mat_2_stb,
  output logic                    input_mat_2_ack,
  output logic [M*P*DATA_W-1:0]   output_mat,
  output logic                    output_mat_stb,
  input  logic                    output_mat_ack,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  localparam int MP        = M * P;
  localparam int N_BATCHES = (MP + N_LANES - 1) / N_LANES;
  // Accumulator holds N full products plus one guard bit.
  localparam int AW        = 2 * DATA_W + $clog2(N) + 1;
  // Writeback sum: shifted accumulator plus the held element.
  localparam int RW        = AW + 1;
  localparam int ROW_W     = (M > 1) ? $clog2(M) : 1;
  localparam int COL_W     = (P > 1) ? $clog2(P) : 1;
  localparam int KI_W      = (N > 1) ? $clog2(N) : 1;
  localparam int KW        = $clog2(N + 1);
  localparam int BW        = (N_BATCHES > 1) ? $clog2(N_BATCHES) : 1;

  typedef enum logic [1:0] {
    GET_MAT_1 = 2'd0,
    GET_MAT_2 = 2'd1,
    COMPUTE   = 2'd2,
    PUT_MAT   = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      acc_mode_q;
  logic [KW-1:0]             k_q;
  logic [BW-1:0]             batch_q;
  logic signed [DATA_W-1:0]  a_q [M][N];
  logic signed [DATA_W-1:0]  b_q [N][P];
  logic signed [DATA_W-1:0]  c_q [M][P];
  logic signed [AW-1:0]      acc_q [N_LANES];

  // Per-lane element mapping for the current batch.
  logic [ROW_W-1:0]          lane_row [N_LANES];
  logic [COL_W-1:0]          lane_col [N_LANES];
  logic                      lane_vld [N_LANES];
  logic [KI_W-1:0]           k_idx;
  logic signed [AW-1:0]      prod [N_LANES];
  logic signed [DATA_W-1:0]  wb_val [N_LANES];

`ifdef MAT_PRODUCT_MAC_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  assign fsm_state = state_q;

  // k_q reaches N only in the writeback cycle, where no operand is read,
  // so dropping its top bit for the operand index is safe.
  assign k_idx = KI_W'(k_q);

  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      int e;
      e = int'(batch_q) * N_LANES + l;
      lane_vld[l] = (e < MP);
      lane_row[l] = '0;
      lane_col[l] = '0;
      if (e < MP) begin
        lane_row[l] = ROW_W'(e / P);
        lane_col[l] = COL_W'(e % P);
      end
    end
  end

  // Products are formed at accumulator width, so both operands are
  // sign-extended before the multiply and nothing is lost.
  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      prod[l] = '0;
      if (lane_vld[l]) begin
        prod[l] = a_q[lane_row[l]][k_idx] * b_q[k_idx][lane_col[l]];
      end
    end
  end

  // Writeback value: rescale (arithmetic shift rounds toward -inf),
  // optionally add the held element, then narrow by saturation or wrap.
  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      logic signed [AW-1:0] shifted;
      logic signed [RW-1:0] r;
      shifted = acc_q[l] >>> FRAC_W;
      r = RW'(shifted);
      if (acc_mode_q) begin
        r = r + RW'(c_q[lane_row[l]][lane_col[l]]);
      end
`ifdef MAT_PRODUCT_MAC_SAT_EN
      if (r > SAT_MAX) begin
        wb_val[l] = SAT_MAX[DATA_W-1:0];
      end else if (r < SAT_MIN) begin
        wb_val[l] = SAT_MIN[DATA_W-1:0];
      end else begin
        wb_val[l] = r[DATA_W-1:0];
      end
`else
      wb_val[l] = r[DATA_W-1:0];
`endif
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_out_row
    for (genvar gj = 0; gj < P; gj++) begin : g_out_col
      assign output_mat[(gi*P+gj)*DATA_W +: DATA_W] = c_q[gi][gj];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= GET_MAT_1;
      input_mat_1_ack <= 1'b0;
      input_mat_2_ack <= 1'b0;
      output_mat_stb  <= 1'b0;
      busy            <= 1'b0;
      acc_mode_q      <= 1'b0;
      k_q             <= '0;
      batch_q         <= '0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          a_q[i][j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < P; j++)
          b_q[i][j] <= '0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++)
          c_q[i][j] <= '0;
      for (int l = 0; l < N_LANES; l++)
        acc_q[l] <= '0;
    end else begin
      case (state_q)
        GET_MAT_1: begin
          if (input_mat_1_ack && input_mat_1_stb) begin
            for (int i = 0; i < M; i++)
              for (int j = 0; j < N; j++)
                a_q[i][j] <= input_mat_1[(i*N+j)*DATA_W +: DATA_W];
            acc_mode_q      <= accumulate;
            busy            <= 1'b1;
            input_mat_1_ack <= 1'b0;
            input_mat_2_ack <= 1'b1;
            state_q         <= GET_MAT_2;
          end else begin
            input_mat_1_ack <= 1'b1;
          end
        end

        GET_MAT_2: begin
          if (input_mat_2_ack && input_mat_2_stb) begin
            for (int i = 0; i < N; i++)
              for (int j = 0; j < P; j++)
                b_q[i][j] <= input_mat_2[(i*P+j)*DATA_W +: DATA_W];
            input_mat_2_ack <= 1'b0;
            batch_q         <= '0;
            k_q             <= '0;
            state_q         <= COMPUTE;
          end else begin
            input_mat_2_ack <= 1'b1;
          end
        end

        COMPUTE: begin
          if (k_q == KW'(N)) begin
            // Writeback cycle: every element is written exactly once per
            // operation, so the accumulate path always sees the old value.
            for (int l = 0; l < N_LANES; l++) begin
              if (lane_vld[l]) begin
                c_q[lane_row[l]][lane_col[l]] <= wb_val[l];
              end
              acc_q[l] <= '0;
            end
            k_q <= '0;
            if (batch_q == BW'(N_BATCHES - 1)) begin
              state_q <= PUT_MAT;
            end else begin
              batch_q <= batch_q + 1'b1;
            end
          end else begin
            for (int l = 0; l < N_LANES; l++) begin
              if (lane_vld[l]) begin
                acc_q[l] <= acc_q[l] + prod[l];
              end
            end
            k_q <= k_q + 1'b1;
          end
        end

        PUT_MAT: begin
          // One cycle to raise stb after the final writeback; then hold
          // until the consumer takes the result.
          if (!output_mat_stb) begin
            output_mat_stb <= 1'b1;
          end else if (output_mat_ack) begin
            output_mat_stb  <= 1'b0;
            busy            <= 1'b0;
            input_mat_1_ack <= 1'b1;
            state_q         <= GET_MAT_1;
          end
        end

        default: begin
          state_q <= GET_MAT_1;
        end
      endcase
    end
  end

endmodule
